// File: rtl/mem_fill_pp.sv
// Multi-channel ping-pong packet buffer: round-robin collects per-channel holders
// into the write bank; banks swap on each main-sync falling edge for the UDP reader.
module mem_fill_pp #(
    parameter int CH_NUM  = 4,
    parameter int DATA_W  = 32,
    parameter int SLOT_AW = 7,
    localparam int CH_AW  = $clog2(CH_NUM),
    localparam int AW     = CH_AW + SLOT_AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_msync_n,
    input  logic [CH_NUM*DATA_W-1:0]   i_ch_data,
    input  logic [CH_NUM*SLOT_AW-1:0]  i_ch_idx,
    input  logic [CH_NUM-1:0]          i_ch_vld,
    output logic [CH_NUM-1:0]          o_ch_rdy,
    input  logic [AW-1:0]              i_rd_addr,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic                       o_frame_rdy,
    output logic [15:0]                o_frame_cnt,
    output logic [AW:0]                o_fill_cnt,
    output logic [15:0]                o_drop_cnt
);
    localparam int DEPTH = 1 << AW;

    // Bank b occupies mem[{b, ch, idx}].
    logic [DATA_W-1:0]  mem [2*DEPTH];

    logic               msync_prev_q, msync_prev_d;
    logic               wr_bank_q, wr_bank_d;
    logic [CH_AW-1:0]   last_grant_q, last_grant_d;
    logic [CH_NUM-1:0]  full_q, full_d;
    logic [DATA_W-1:0]  hold_data_q [CH_NUM];
    logic [DATA_W-1:0]  hold_data_d [CH_NUM];
    logic [SLOT_AW-1:0] hold_idx_q [CH_NUM];
    logic [SLOT_AW-1:0] hold_idx_d [CH_NUM];
    logic [AW:0]        fill_acc_q, fill_acc_d;
    logic [AW:0]        fill_cnt_q, fill_cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               frame_rdy_q, frame_rdy_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic               sync;
    logic               gnt_vld;
    logic [CH_AW-1:0]   gnt_ch;
    logic [CH_AW-1:0]   cand;
    logic [CH_NUM-1:0]  grant;
    logic [CH_NUM-1:0]  accept;
    logic [CH_AW:0]     pop;
    logic [16:0]        drop_sum;

    assign sync = msync_prev_q & ~i_msync_n;

    // Round-robin: search upward from last_grant+1, wrapping; nothing is granted in a sync cycle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            cand = CH_AW'((int'(last_grant_q) + k) % CH_NUM);
            if (!gnt_vld && full_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
        if (sync) gnt_vld = 1'b0;
        grant = '0;
        if (gnt_vld) grant[gnt_ch] = 1'b1;
    end

    // Valid/ready: a word transfers on a cycle where i_ch_vld[c] & o_ch_rdy[c]; a holder
    // takes a new word when empty or draining this cycle, never during sync or reset.
    assign o_ch_rdy = rst ? '0 : ((~full_q | grant) & {CH_NUM{~sync}});
    assign accept   = i_ch_vld & o_ch_rdy;

    always_comb begin
        full_d      = full_q;
        hold_data_d = hold_data_q;
        hold_idx_d  = hold_idx_q;
        pop         = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            pop = pop + (CH_AW+1)'(full_q[c]);
            if (sync) begin
                full_d[c] = 1'b0;
            end else if (accept[c]) begin
                full_d[c]      = 1'b1;
                hold_data_d[c] = i_ch_data[c*DATA_W +: DATA_W];
                hold_idx_d[c]  = i_ch_idx[c*SLOT_AW +: SLOT_AW];
            end else if (grant[c]) begin
                full_d[c] = 1'b0;
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt_q} + 17'(pop);

    always_comb begin
        msync_prev_d = i_msync_n;
        wr_bank_d    = wr_bank_q;
        last_grant_d = gnt_vld ? gnt_ch : last_grant_q;
        fill_acc_d   = fill_acc_q;
        fill_cnt_d   = fill_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        frame_rdy_d  = sync;
        rd_data_d    = mem[{~wr_bank_q, i_rd_addr}];
        if (sync) begin
            wr_bank_d   = ~wr_bank_q;
            fill_cnt_d  = fill_acc_q;
            fill_acc_d  = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            drop_cnt_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end else if (gnt_vld) begin
            fill_acc_d = fill_acc_q + 1'b1;
        end
    end

    // RAM is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (gnt_vld) mem[{wr_bank_q, gnt_ch, hold_idx_q[gnt_ch]}] <= hold_data_q[gnt_ch];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msync_prev_q <= 1'b0;
            wr_bank_q    <= 1'b0;
            last_grant_q <= CH_AW'(CH_NUM - 1);
            full_q       <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                hold_data_q[c] <= '0;
                hold_idx_q[c]  <= '0;
            end
            fill_acc_q   <= '0;
            fill_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            frame_rdy_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            msync_prev_q <= msync_prev_d;
            wr_bank_q    <= wr_bank_d;
            last_grant_q <= last_grant_d;
            full_q       <= full_d;
            hold_data_q  <= hold_data_d;
            hold_idx_q   <= hold_idx_d;
            fill_acc_q   <= fill_acc_d;
            fill_cnt_q   <= fill_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_rdy_q  <= frame_rdy_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign o_rd_data   = rd_data_q;
    assign o_frame_rdy = frame_rdy_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_fill_cnt  = fill_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mem_fill_pp.sv
// Directed bench for mem_fill_pp: reset, single write, full-load round robin,
// sync-time drops, bank swapping and drop-counter saturation.
module tb_mem_fill_pp;
    localparam int CH_NUM  = 4;
    localparam int DATA_W  = 32;
    localparam int SLOT_AW = 7;
    localparam int AW      = 9;

    logic                      clk;
    logic                      rst;
    logic                      i_msync_n;
    logic [CH_NUM*DATA_W-1:0]  i_ch_data;
    logic [CH_NUM*SLOT_AW-1:0] i_ch_idx;
    logic [CH_NUM-1:0]         i_ch_vld;
    logic [CH_NUM-1:0]         o_ch_rdy;
    logic [AW-1:0]             i_rd_addr;
    logic [DATA_W-1:0]         o_rd_data;
    logic                      o_frame_rdy;
    logic [15:0]               o_frame_cnt;
    logic [AW:0]               o_fill_cnt;
    logic [15:0]               o_drop_cnt;

    int n_vec;
    int n_err;

    mem_fill_pp #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .SLOT_AW(SLOT_AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_msync_n   (i_msync_n),
        .i_ch_data   (i_ch_data),
        .i_ch_idx    (i_ch_idx),
        .i_ch_vld    (i_ch_vld),
        .o_ch_rdy    (o_ch_rdy),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_frame_rdy (o_frame_rdy),
        .o_frame_cnt (o_frame_cnt),
        .o_fill_cnt  (o_fill_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_msync_n = 1'b1;
        i_ch_data = '0;
        i_ch_idx  = '0;
        i_ch_vld  = '0;
        i_rd_addr = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- drivers ----------------
    task automatic do_sync;
        i_msync_n = 1'b0;
        tick();
        i_msync_n = 1'b1;
    endtask

    task automatic send_word(input int c, input logic [SLOT_AW-1:0] idx, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        i_ch_vld[c] = 1'b1;
        i_ch_data[c*DATA_W +: DATA_W] = d;
        i_ch_idx[c*SLOT_AW +: SLOT_AW] = idx;
        #1;
        while (o_ch_rdy[c] !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        n_vec++;
        if (o_ch_rdy[c] !== 1'b1) begin
            n_err++;
            $display("FAIL send_rdy_timeout ch%0d: rdy=%b, required 1", c, o_ch_rdy[c]);
        end
        tick();
        i_ch_vld[c] = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (o_ch_rdy !== 4'h0) begin n_err++; $display("FAIL rst_rdy: got %h, required 0", o_ch_rdy); end
        n_vec++; if (o_rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd_data: got %h, required 0", o_rd_data); end
        n_vec++; if (o_frame_rdy !== 1'b0) begin n_err++; $display("FAIL rst_frame_rdy: got %b, required 0", o_frame_rdy); end
        n_vec++; if (o_frame_cnt !== 16'h0) begin n_err++; $display("FAIL rst_frame_cnt: got %h, required 0", o_frame_cnt); end
        n_vec++; if (o_fill_cnt !== 10'h0) begin n_err++; $display("FAIL rst_fill_cnt: got %h, required 0", o_fill_cnt); end
        n_vec++; if (o_drop_cnt !== 16'h0) begin n_err++; $display("FAIL rst_drop_cnt: got %h, required 0", o_drop_cnt); end
        rst = 1'b0;
        #1;
        n_vec++; if (o_ch_rdy !== 4'hF) begin n_err++; $display("FAIL release_rdy: got %h, required f", o_ch_rdy); end
        tick();
        do_sync();
        n_vec++; if (o_frame_rdy !== 1'b1) begin n_err++; $display("FAIL empty_frame_rdy: got %b, required 1", o_frame_rdy); end
        n_vec++; if (o_frame_cnt !== 16'd1) begin n_err++; $display("FAIL empty_frame_cnt: got %0d, required 1", o_frame_cnt); end
        n_vec++; if (o_fill_cnt !== 10'd0) begin n_err++; $display("FAIL empty_fill_cnt: got %0d, required 0", o_fill_cnt); end
        tick();
        n_vec++; if (o_frame_rdy !== 1'b0) begin n_err++; $display("FAIL frame_rdy_pulse: got %b, required 0", o_frame_rdy); end
    endtask

    task automatic test_single_write;
        send_word(0, 7'd5, 32'hA5A5_0001);
        do_sync();
        n_vec++; if (o_fill_cnt !== 10'd1) begin n_err++; $display("FAIL single_fill_cnt: got %0d, required 1", o_fill_cnt); end
        n_vec++; if (o_frame_cnt !== 16'd2) begin n_err++; $display("FAIL single_frame_cnt: got %0d, required 2", o_frame_cnt); end
        i_rd_addr = 9'd5;
        tick();
        n_vec++; if (o_rd_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_read: got %h, required a5a50001", o_rd_data); end
    endtask

    task automatic test_all_channels;
        int sent [CH_NUM];
        logic [CH_NUM-1:0] acc;
        logic [CH_NUM-1:0] exp_rdy;
        logic [DATA_W-1:0] exp_d;
        do_reset();
        for (int c = 0; c < CH_NUM; c++) sent[c] = 0;
        for (int cyc = 0; cyc < 132; cyc++) begin
            for (int c = 0; c < CH_NUM; c++) begin
                i_ch_vld[c] = (sent[c] < 32);
                i_ch_data[c*DATA_W +: DATA_W] = 32'hC000_0000 | 32'(c << 8) | 32'(sent[c]);
                i_ch_idx[c*SLOT_AW +: SLOT_AW] = 7'(sent[c]);
            end
            #1;
            exp_rdy = (cyc == 0) ? 4'hF : 4'(1 << ((cyc - 1) % 4));
            if (cyc <= 120) begin
                n_vec++;
                if (o_ch_rdy !== exp_rdy) begin
                    n_err++;
                    $display("FAIL rr_rdy cycle %0d: got %b, required %b", cyc, o_ch_rdy, exp_rdy);
                end
            end
            acc = i_ch_vld & o_ch_rdy;
            tick();
            for (int c = 0; c < CH_NUM; c++) if (acc[c]) sent[c]++;
        end
        i_ch_vld = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            n_vec++;
            if (sent[c] != 32) begin n_err++; $display("FAIL rr_accepted ch%0d: got %0d, required 32", c, sent[c]); end
        end
        do_sync();
        n_vec++; if (o_fill_cnt !== 10'd128) begin n_err++; $display("FAIL rr_fill_cnt: got %0d, required 128", o_fill_cnt); end
        n_vec++; if (o_frame_cnt !== 16'd1) begin n_err++; $display("FAIL rr_frame_cnt: got %0d, required 1", o_frame_cnt); end
        for (int c = 0; c < CH_NUM; c++) begin
            for (int k = 0; k < 32; k++) begin
                i_rd_addr = {2'(c), 7'(k)};
                exp_d = 32'hC000_0000 | 32'(c << 8) | 32'(k);
                tick();
                n_vec++;
                if (o_rd_data !== exp_d) begin
                    n_err++;
                    $display("FAIL rr_read ch%0d idx%0d: got %h, required %h", c, k, o_rd_data, exp_d);
                end
            end
        end
    endtask

    // Bank 0 still holds 32'hC000_0207 at {2,7} from the full-load frame.
    task automatic test_sync_drop;
        do_reset();
        i_ch_vld[2] = 1'b1;
        i_ch_data[2*DATA_W +: DATA_W] = 32'hDEAD_0002;
        i_ch_idx[2*SLOT_AW +: SLOT_AW] = 7'd7;
        tick();
        i_msync_n = 1'b0;
        i_ch_data[2*DATA_W +: DATA_W] = 32'hDEAD_0003;
        #1;
        n_vec++; if (o_ch_rdy !== 4'h0) begin n_err++; $display("FAIL sync_rdy: got %b, required 0000", o_ch_rdy); end
        tick();
        i_msync_n = 1'b1;
        i_ch_vld = '0;
        n_vec++; if (o_drop_cnt !== 16'd1) begin n_err++; $display("FAIL sync_drop_cnt: got %0d, required 1", o_drop_cnt); end
        n_vec++; if (o_fill_cnt !== 10'd0) begin n_err++; $display("FAIL sync_drop_fill: got %0d, required 0", o_fill_cnt); end
        i_rd_addr = {2'd2, 7'd7};
        tick();
        n_vec++; if (o_rd_data !== 32'hC000_0207) begin n_err++; $display("FAIL sync_drop_read: got %h, required c0000207", o_rd_data); end
    endtask

    task automatic test_bank_swap;
        send_word(1, 7'd3, 32'hE100_0001);
        do_sync();
        i_rd_addr = {2'd1, 7'd3};
        tick();
        n_vec++; if (o_rd_data !== 32'hE100_0001) begin n_err++; $display("FAIL swap_frame_n: got %h, required e1000001", o_rd_data); end
        send_word(1, 7'd3, 32'hE200_0002);
        n_vec++; if (o_rd_data !== 32'hE100_0001) begin n_err++; $display("FAIL swap_midframe: got %h, required e1000001", o_rd_data); end
        i_msync_n = 1'b0;
        tick();
        i_msync_n = 1'b1;
        n_vec++; if (o_rd_data !== 32'hE100_0001) begin n_err++; $display("FAIL swap_read_in_sync: got %h, required e1000001", o_rd_data); end
        n_vec++; if (o_fill_cnt !== 10'd1) begin n_err++; $display("FAIL swap_fill_cnt: got %0d, required 1", o_fill_cnt); end
        tick();
        n_vec++; if (o_rd_data !== 32'hE200_0002) begin n_err++; $display("FAIL swap_frame_n1: got %h, required e2000002", o_rd_data); end
    endtask

    task automatic test_drop_saturation;
        do_reset();
        i_ch_vld = 4'hF;
        for (int p = 0; p < 17500; p++) begin
            i_msync_n = 1'b1;
            tick();
            i_msync_n = 1'b0;
            tick();
            if (p == 99) begin
                n_vec++; if (o_drop_cnt !== 16'd400) begin n_err++; $display("FAIL drop_cnt_100: got %0d, required 400", o_drop_cnt); end
                n_vec++; if (o_frame_cnt !== 16'd100) begin n_err++; $display("FAIL frame_cnt_100: got %0d, required 100", o_frame_cnt); end
            end
        end
        i_msync_n = 1'b1;
        i_ch_vld = '0;
        n_vec++; if (o_drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL drop_saturate: got %h, required ffff", o_drop_cnt); end
        n_vec++; if (o_frame_cnt !== 16'd17500) begin n_err++; $display("FAIL frame_cnt_17500: got %0d, required 17500", o_frame_cnt); end
        n_vec++; if (o_fill_cnt !== 10'd0) begin n_err++; $display("FAIL drop_fill_cnt: got %0d, required 0", o_fill_cnt); end
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (o_drop_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_drop: got %h, required 0", o_drop_cnt); end
        n_vec++; if (o_frame_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_frame_cnt: got %h, required 0", o_frame_cnt); end
        n_vec++; if (o_ch_rdy !== 4'h0) begin n_err++; $display("FAIL midrst_rdy: got %b, required 0000", o_ch_rdy); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_all_channels();
        test_sync_drop();
        test_bank_swap();
        test_drop_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
